// File: rtl/tinyqv_mem_pkg.sv
// TinyQV memory responder: shared op encodings and FSM states.
// Optional build macro: TQV_MEM_RESPONDER_MISALIGN_EN.
package tinyqv_mem_pkg;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_WAIT,
    S_LOAD_SYNC,
    S_LOAD_STREAM,
    S_STORE_RX,
    S_STORE_COMMIT
  } state_t;

  // Unused funct3 codes behave as a word access.
  function automatic logic [2:0] norm_op(input logic [2:0] op);
    case (op)
      OP_B, OP_H, OP_BU, OP_HU: return op;
      default:                  return OP_W;
    endcase
  endfunction

endpackage

// File: rtl/tinyqv_load_align.sv
// TinyQV memory responder: load lane select and extension.
// Pure combinational; op is already normalised.
module tinyqv_load_align
  import tinyqv_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  op,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  // Pick the addressed lane, then sign or zero extend.
  always_comb begin
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (op)
      OP_B:    result = {{24{b[7]}}, b};
      OP_BU:   result = {24'h0, b};
      OP_H:    result = {{16{h[15]}}, h};
      OP_HU:   result = {16'h0, h};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/tinyqv_mem_responder.sv
// TinyQV nibble-serial memory responder (byte-addressed RAM).
// Optional build macro: TQV_MEM_RESPONDER_MISALIGN_EN.
module tinyqv_mem_responder
  import tinyqv_mem_pkg::*;
#(
  parameter int LATENCY   = 2,
  parameter int ADDR_BITS = 6
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [27:0] addr_in,
  input  logic        address_ready,
  input  logic        is_store,
  input  logic [2:0]  mem_op,
  input  logic [2:0]  counter,
  input  logic [3:0]  wdata_nibble,
  output logic [3:0]  rdata_nibble,
  output logic        load_data_ready,
  output logic        store_done,
  output logic        busy,
  output logic        error
);

  state_t                 state;
  logic [ADDR_BITS-1:0]   addr;
  logic [2:0]             op;
  logic                   mis;
  logic [2:0]             wcnt;
  logic [31:0]            result;
  logic [31:0]            wbuf;
  logic                   err_q;
  logic [7:0]             mem [2**ADDR_BITS];

  logic                   start;
  logic [2:0]             in_op;
  logic [ADDR_BITS-1:0]   cap_addr;
  logic                   cap_mis;
  logic [31:0]            rd_word;
  logic [31:0]            aligned;
  logic [3:0]             be;
  logic [31:0]            wlane;
  logic                   unused_hi;

  assign unused_hi = ^addr_in[27:ADDR_BITS];
  assign start = address_ready && state == S_IDLE
              && counter == 3'd0;
  assign in_op = norm_op(mem_op);

  // Capture-time alignment: flag or truncate.
  always_comb begin
    cap_addr = addr_in[ADDR_BITS-1:0];
    cap_mis  = 1'b0;
`ifdef TQV_MEM_RESPONDER_MISALIGN_EN
    cap_mis = (in_op[1:0] == 2'b01 && addr_in[0])
           || (in_op == OP_W && addr_in[1:0] != 2'b00);
`else
    if (in_op[1:0] == 2'b01)
      cap_addr[0] = 1'b0;
    if (in_op == OP_W)
      cap_addr[1:0] = 2'b00;
`endif
  end

  assign rd_word = {
    mem[{addr[ADDR_BITS-1:2], 2'd3}],
    mem[{addr[ADDR_BITS-1:2], 2'd2}],
    mem[{addr[ADDR_BITS-1:2], 2'd1}],
    mem[{addr[ADDR_BITS-1:2], 2'd0}]
  };

  tinyqv_load_align u_align (
    .word   (rd_word),
    .off    (addr[1:0]),
    .op     (op),
    .result (aligned)
  );

  // Transaction FSM and latched request fields.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= S_IDLE;
      addr   <= '0;
      op     <= OP_B;
      mis    <= 1'b0;
      wcnt   <= 3'd0;
      result <= 32'h0;
      wbuf   <= 32'h0;
      err_q  <= 1'b0;
    end else begin
      err_q <= (address_ready && !start)
            || (start && cap_mis);
      unique case (state)
        S_IDLE: if (start) begin
          addr  <= cap_addr;
          op    <= in_op;
          mis   <= cap_mis;
          wcnt  <= 3'd0;
          wbuf  <= {28'h0, wdata_nibble};
          state <= is_store ? S_STORE_RX : S_LOAD_WAIT;
        end
        S_LOAD_WAIT: begin
          wcnt <= wcnt + 3'd1;
          if (wcnt == 3'(LATENCY - 1)) begin
            result <= mis ? 32'h0 : aligned;
            state  <= S_LOAD_SYNC;
          end
        end
        S_LOAD_SYNC:
          if (counter == 3'd7) state <= S_LOAD_STREAM;
        S_LOAD_STREAM:
          if (counter == 3'd7) state <= S_IDLE;
        S_STORE_RX: begin
          wbuf[4*counter +: 4] <= wdata_nibble;
          if (counter == 3'd7) state <= S_STORE_COMMIT;
        end
        S_STORE_COMMIT: state <= S_IDLE;
        default:        state <= S_IDLE;
      endcase
    end
  end

  // Byte enables and lane-replicated write data.
  always_comb begin
    be    = 4'hF;
    wlane = wbuf;
    unique case (1'b1)
      op[1:0] == 2'b00: begin
        be    = 4'b0001 << addr[1:0];
        wlane = {4{wbuf[7:0]}};
      end
      op[1:0] == 2'b01: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wbuf[15:0]}};
      end
      default: begin
        be    = 4'hF;
        wlane = wbuf;
      end
    endcase
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (state == S_STORE_COMMIT && !mis)
      for (int i = 0; i < 4; i++)
        if (be[i])
          mem[{addr[ADDR_BITS-1:2], 2'(i)}] <= wlane[8*i +: 8];
  end

  assign busy            = state != S_IDLE;
  assign load_data_ready = state == S_LOAD_SYNC && counter == 3'd7;
  assign store_done      = state == S_STORE_COMMIT;
  assign error           = err_q;
  assign rdata_nibble    = (state == S_LOAD_STREAM)
                         ? result[4*counter +: 4] : 4'h0;

endmodule

// File: tb/tb_tinyqv_mem_responder.sv
// Directed bench for tinyqv_mem_responder.
// Three instances (LATENCY 2, 1, 7) share all inputs.
module tb_tinyqv_mem_responder;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [27:0] addr_in = '0;
  logic        ar = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  mem_op = 3'b000;
  logic [2:0]  cnt = 3'd0;
  logic [3:0]  wdata = 4'h0;

  logic [3:0]  rd [3];
  logic        ldr [3];
  logic        sd [3];
  logic        bsy [3];
  logic        err [3];

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] gd [3];
  int          glc [3];
  int          nc [3];
  logic        err_seen;
  logic        sd_seen;
  int          exp_lc [3] = '{7, 7, 15};

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 3'd1;

  tinyqv_mem_responder #(.LATENCY(2), .ADDR_BITS(6)) dut (
    .clk(clk), .rstn(rstn), .addr_in(addr_in),
    .address_ready(ar), .is_store(is_store),
    .mem_op(mem_op), .counter(cnt), .wdata_nibble(wdata),
    .rdata_nibble(rd[0]), .load_data_ready(ldr[0]),
    .store_done(sd[0]), .busy(bsy[0]), .error(err[0]));

  tinyqv_mem_responder #(.LATENCY(1), .ADDR_BITS(6)) dut1 (
    .clk(clk), .rstn(rstn), .addr_in(addr_in),
    .address_ready(ar), .is_store(is_store),
    .mem_op(mem_op), .counter(cnt), .wdata_nibble(wdata),
    .rdata_nibble(rd[1]), .load_data_ready(ldr[1]),
    .store_done(sd[1]), .busy(bsy[1]), .error(err[1]));

  tinyqv_mem_responder #(.LATENCY(7), .ADDR_BITS(6)) dut7 (
    .clk(clk), .rstn(rstn), .addr_in(addr_in),
    .address_ready(ar), .is_store(is_store),
    .mem_op(mem_op), .counter(cnt), .wdata_nibble(wdata),
    .rdata_nibble(rd[2]), .load_data_ready(ldr[2]),
    .store_done(sd[2]), .busy(bsy[2]), .error(err[2]));

  task automatic wait_cnt(input logic [2:0] v);
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (cnt != v && g < 16);
  endtask

  task automatic do_store(input logic [27:0] a,
                          input logic [2:0] op,
                          input logic [31:0] d);
    wait_cnt(3'd0);
    ar = 1'b1; is_store = 1'b1;
    addr_in = a; mem_op = op; wdata = d[3:0];
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      ar = 1'b0;
      wdata = d[4*i +: 4];
    end
    @(negedge clk);
    sd_seen = sd[0];
    is_store = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_load(input logic [27:0] a,
                         input logic [2:0] op,
                         input bit inject);
    wait_cnt(3'd0);
    ar = 1'b1; is_store = 1'b0;
    addr_in = a; mem_op = op;
    err_seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      gd[k] = 32'h0; glc[k] = -1; nc[k] = 0;
    end
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        ar = 1'b0;
        if (inject) begin
          ar = 1'b1; is_store = 1'b1;
          addr_in = 28'h3C; mem_op = 3'b010;
        end
      end
      if (cyc == 2) begin
        ar = 1'b0; is_store = 1'b0;
      end
      if (err[0]) err_seen = 1'b1;
      for (int k = 0; k < 3; k++) begin
        if (glc[k] >= 0 && nc[k] < 8) begin
          gd[k][4*nc[k] +: 4] = rd[k];
          nc[k]++;
        end
        if (ldr[k] && glc[k] < 0) glc[k] = cyc;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++;
    if ({rd[0], ldr[0], sd[0], bsy[0], err[0]} !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_outs got %b want 0",
               {rd[0], ldr[0], sd[0], bsy[0], err[0]});
    end
    rstn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bsy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy got %b want 0", bsy[0]);
    end
  endtask

  task automatic test_word;
    do_store(28'h10, 3'b010, 32'hDEADBEEF);
    n_checks++;
    if (sd_seen !== 1'b1) begin
      n_fail++;
      $display("FAIL word_store_done got %b want 1", sd_seen);
    end
    do_load(28'h10, 3'b010, 1'b0);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (gd[k] !== 32'hDEADBEEF) begin
        n_fail++;
        $display("FAIL word_data[%0d] got %h want deadbeef", k, gd[k]);
      end
      n_checks++;
      if (glc[k] != exp_lc[k]) begin
        n_fail++;
        $display("FAIL ldr_timing[%0d] got %0d want %0d",
                 k, glc[k], exp_lc[k]);
      end
    end
    n_checks++;
    if (err_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL word_err got %b want 0", err_seen);
    end
  endtask

  task automatic test_byte;
    do_store(28'h13, 3'b000, 32'h00000080);
    do_load(28'h13, 3'b000, 1'b0);
    n_checks++;
    if (gd[0] !== 32'hFFFFFF80) begin
      n_fail++;
      $display("FAIL load_b got %h want ffffff80", gd[0]);
    end
    do_load(28'h13, 3'b100, 1'b0);
    n_checks++;
    if (gd[0] !== 32'h00000080) begin
      n_fail++;
      $display("FAIL load_bu got %h want 00000080", gd[0]);
    end
    do_load(28'h10, 3'b010, 1'b0);
    n_checks++;
    if (gd[0] !== 32'h80ADBEEF) begin
      n_fail++;
      $display("FAIL load_w10 got %h want 80adbeef", gd[0]);
    end
    do_load(28'h12, 3'b001, 1'b0);
    n_checks++;
    if (gd[0] !== 32'hFFFF80AD) begin
      n_fail++;
      $display("FAIL load_h got %h want ffff80ad", gd[0]);
    end
    do_load(28'h12, 3'b101, 1'b0);
    n_checks++;
    if (gd[0] !== 32'h000080AD) begin
      n_fail++;
      $display("FAIL load_hu got %h want 000080ad", gd[0]);
    end
  endtask

  task automatic test_alias;
    do_load(28'hABCD050, 3'b010, 1'b0);
    n_checks++;
    if (gd[0] !== 32'h80ADBEEF) begin
      n_fail++;
      $display("FAIL alias_load got %h want 80adbeef", gd[0]);
    end
    do_load(28'h10, 3'b111, 1'b0);
    n_checks++;
    if (gd[0] !== 32'h80ADBEEF) begin
      n_fail++;
      $display("FAIL op111_load got %h want 80adbeef", gd[0]);
    end
    do_store(28'h0000070, 3'b110, 32'h55667788);
    do_load(28'h30, 3'b010, 1'b0);
    n_checks++;
    if (gd[0] !== 32'h55667788) begin
      n_fail++;
      $display("FAIL op110_alias_store got %h want 55667788", gd[0]);
    end
  endtask

  task automatic test_errors;
    wait_cnt(3'd3);
    ar = 1'b1;
    @(negedge clk);
    ar = 1'b0;
    n_checks++;
    if (err[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_err got %b want 1", err[0]);
    end
    n_checks++;
    if (bsy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_err_busy got %b want 0", bsy[0]);
    end
    @(negedge clk);
    n_checks++;
    if (err[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL err_pulse_len got %b want 0", err[0]);
    end
    do_load(28'h10, 3'b010, 1'b1);
    n_checks++;
    if (err_seen !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_err got %b want 1", err_seen);
    end
    n_checks++;
    if (gd[0] !== 32'h80ADBEEF || glc[0] != 7) begin
      n_fail++;
      $display("FAIL wait_err_load got %h/%0d want 80adbeef/7",
               gd[0], glc[0]);
    end
  endtask

  task automatic test_reset_mid_store;
    logic [31:0] d;
    do_store(28'h20, 3'b010, 32'h11223344);
    d = 32'hCAFEF00D;
    wait_cnt(3'd0);
    ar = 1'b1; is_store = 1'b1;
    addr_in = 28'h20; mem_op = 3'b010; wdata = d[3:0];
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      ar = 1'b0;
      wdata = d[4*i +: 4];
    end
    @(negedge clk);
    n_checks++;
    if (bsy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL rx_busy got %b want 1", bsy[0]);
    end
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({rd[0], ldr[0], sd[0], bsy[0], err[0]} !== 8'h0) begin
      n_fail++;
      $display("FAIL midreset_outs got %b want 0",
               {rd[0], ldr[0], sd[0], bsy[0], err[0]});
    end
    @(negedge clk);
    is_store = 1'b0;
    rstn = 1'b1;
    do_load(28'h20, 3'b010, 1'b0);
    n_checks++;
    if (gd[0] !== 32'h11223344) begin
      n_fail++;
      $display("FAIL midreset_mem got %h want 11223344", gd[0]);
    end
    do_store(28'h22, 3'b001, 32'h00001234);
    do_load(28'h20, 3'b010, 1'b0);
    n_checks++;
    if (gd[0] !== 32'h12343344) begin
      n_fail++;
      $display("FAIL store_h got %h want 12343344", gd[0]);
    end
  endtask

  task automatic test_misalign;
    do_load(28'h11, 3'b001, 1'b0);
`ifdef TQV_MEM_RESPONDER_MISALIGN_EN
    n_checks++;
    if (err_seen !== 1'b1 || gd[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL mis_load got err=%b d=%h want err=1 d=0",
               err_seen, gd[0]);
    end
`else
    n_checks++;
    if (err_seen !== 1'b0 || gd[0] !== 32'hFFFFBEEF) begin
      n_fail++;
      $display("FAIL trunc_load got err=%b d=%h want err=0 d=ffffbeef",
               err_seen, gd[0]);
    end
`endif
    n_checks++;
    if (glc[0] != 7) begin
      n_fail++;
      $display("FAIL mis_timing got %0d want 7", glc[0]);
    end
    do_store(28'h21, 3'b010, 32'hA5A5A5A5);
    do_load(28'h20, 3'b010, 1'b0);
`ifdef TQV_MEM_RESPONDER_MISALIGN_EN
    n_checks++;
    if (gd[0] !== 32'h12343344) begin
      n_fail++;
      $display("FAIL mis_store got %h want 12343344", gd[0]);
    end
`else
    n_checks++;
    if (gd[0] !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL trunc_store got %h want a5a5a5a5", gd[0]);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_word;
    test_byte;
    test_alias;
    test_errors;
    test_reset_mid_store;
    test_misalign;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
